// File: rtl/brightness_keys_pkg.sv
// brightness_pkg: shared key FSM type, default timing constants and counter sizing
package brightness_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} key_state_t;

    localparam int DEF_DB_CYCLES  = 500000;
    localparam int DEF_RPT_DELAY  = 25000000;
    localparam int DEF_RPT_PERIOD = 5000000;

    localparam logic KEY_PRESSED = 1'b0;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/brightness_keys_if.sv
// brightness_keys_if: raw keys and frame strobe in, brightness requests and held state out
interface brightness_keys_if;
    logic       key_up_n;
    logic       key_dn_n;
    logic       frame_start;
    logic       inc;
    logic       dec;
    logic       lvl_rst;
    logic [1:0] held;

    modport master (output key_up_n, key_dn_n, frame_start, input inc, dec, lvl_rst, held);
    modport slave  (input key_up_n, key_dn_n, frame_start, output inc, dec, lvl_rst, held);
endinterface

// File: rtl/brightness_keys_debounce.sv
// key_debounce: 2-flop synchroniser and stable-level debounce for one active-low key
module key_debounce
    import brightness_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CW        = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (sync[1] != level) && (cnt == CW'(DB_CYCLES - 1));

    // bring the asynchronous key into the clock domain; idle state is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else sync <= {sync[0], key_n};
    end

    // accept a new level only after it has differed for DB_CYCLES consecutive cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= ~KEY_PRESSED;
            press <= 1'b0;
        end else begin
            cnt   <= (sync[1] == level || flip) ? '0 : cnt + CW'(1);
            level <= flip ? sync[1] : level;
            press <= flip && (sync[1] == KEY_PRESSED);
        end
    end
endmodule

// File: rtl/brightness_keys.sv
// brightness_keys: key conditioning, auto-repeat, chord reset and frame-aligned request issue
module brightness_keys
    import brightness_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter int SYNC_FRAME = 1
) (
    input logic clk,
    input logic rst,
    brightness_keys_if.slave bus
);
    localparam int CW = cnt_width(DB_CYCLES, RPT_DELAY, RPT_PERIOD);

    logic [1:0] pressed;
    logic [1:0] ev;
    logic       chord_q;
    logic       both;
    logic       block;
    logic       chord_ev;
    logic       iss;
    logic       p_inc;
    logic       p_dec;
    logic       p_rst;

    assign both     = &pressed;
    assign block    = both | chord_q;
    assign chord_ev = both & ~chord_q;
    assign iss      = (SYNC_FRAME != 0) ? bus.frame_start : 1'b1;
    assign bus.held = pressed;

    // index 1 is the up key, index 0 the down key
    for (genvar k = 0; k < 2; k++) begin : g_key
        key_state_t    state;
        key_state_t    state_nx;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nx;
        logic          lvl;
        logic          prs;
        logic          ev_k;

        key_debounce #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db (
            .clk   (clk),
            .rst   (rst),
            .key_n (k == 1 ? bus.key_up_n : bus.key_dn_n),
            .level (lvl),
            .press (prs)
        );

        assign pressed[k] = (lvl == KEY_PRESSED);
        assign ev[k]      = ev_k;

        // hold timing: press event, initial delay, then periodic repeat; chord or release parks in IDLE
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            ev_k     = 1'b0;
            if (!pressed[k] || block) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (prs) begin
                            ev_k     = 1'b1;
                            state_nx = DELAY;
                            cnt_nx   = '0;
                        end
                    end
                    DELAY: begin
                        if (cnt == CW'(RPT_DELAY - 1)) begin
                            ev_k     = 1'b1;
                            state_nx = REPEAT;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                    default: begin
                        if (cnt == CW'(RPT_PERIOD - 1)) begin
                            ev_k   = 1'b1;
                            cnt_nx = '0;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                endcase
            end
        end

        // key FSM state and hold counter
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end
    end

    // chord stays latched until both keys are released, so it fires once per chord
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chord_q <= 1'b0;
        else chord_q <= both | (chord_q & |pressed);
    end

    // every issue point consumes all flags; events landing on an issue point wait for the next one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_inc       <= 1'b0;
            p_dec       <= 1'b0;
            p_rst       <= 1'b0;
            bus.inc     <= 1'b0;
            bus.dec     <= 1'b0;
            bus.lvl_rst <= 1'b0;
        end else begin
            bus.lvl_rst <= iss & p_rst;
            bus.inc     <= iss & ~p_rst & p_inc & ~p_dec;
            bus.dec     <= iss & ~p_rst & p_dec & ~p_inc;
            p_rst       <= chord_ev | (~iss & p_rst);
            p_inc       <= ev[1] | (~iss & p_inc);
            p_dec       <= ev[0] | (~iss & p_dec);
        end
    end
endmodule

// File: tb/tb_brightness_keys.sv
// tb_brightness_keys: directed scenarios plus randomized keys against a behavioural model
module tb_brightness_keys;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ku  = 1'b1;
    logic kd  = 1'b1;
    logic fs  = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int held_nz  = 0;

    int inc0[$], dec0[$], rst0[$], inc1[$], dec1[$], rst1[$];

    brightness_keys_if bi0 ();
    brightness_keys_if bi1 ();

    assign bi0.key_up_n    = ku;
    assign bi0.key_dn_n    = kd;
    assign bi0.frame_start = fs;
    assign bi1.key_up_n    = ku;
    assign bi1.key_dn_n    = kd;
    assign bi1.frame_start = fs;

    brightness_keys #(.DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .SYNC_FRAME(0)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (bi0)
    );

    brightness_keys #(.DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .SYNC_FRAME(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bi1)
    );

    always #5 clk = ~clk;

    // behavioural model: [0] = down key, [1] = up key; instance 0 issues every cycle, 1 on frame_start
    bit [DB+1:0] hist [2];
    bit          mdb [2];
    bit          mpress [2];
    int          nxt [2];
    bit          evk [2];
    bit          evc;
    bit          chq;
    bit [2:0]    pf [2];
    bit          einc [2];
    bit          edec [2];
    bit          erst [2];
    int          mcyc = 0;

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            hist[j]   = '1;
            mdb[j]    = 1'b1;
            mpress[j] = 1'b0;
            nxt[j]    = -1;
            evk[j]    = 1'b0;
            pf[j]     = '0;
            einc[j]   = 1'b0;
            edec[j]   = 1'b0;
            erst[j]   = 1'b0;
        end
        evc = 1'b0;
        chq = 1'b0;
    endtask

    task automatic model_step();
        bit raw [2];
        bit iss, both, any, blk;
        raw[0] = kd;
        raw[1] = ku;
        for (int s = 0; s < 2; s++) begin
            iss     = (s == 0) ? 1'b1 : fs;
            erst[s] = iss & pf[s][2];
            einc[s] = iss & ~pf[s][2] & pf[s][1] & ~pf[s][0];
            edec[s] = iss & ~pf[s][2] & pf[s][0] & ~pf[s][1];
            pf[s]   = iss ? {evc, evk[1], evk[0]} : (pf[s] | {evc, evk[1], evk[0]});
        end
        for (int j = 0; j < 2; j++) begin
            hist[j]   = {hist[j][DB:0], raw[j]};
            mpress[j] = 1'b0;
            if (hist[j][DB+1:2] == {DB{!mdb[j]}}) begin
                mdb[j]    = !mdb[j];
                mpress[j] = !mdb[j];
            end
        end
        both = !mdb[0] && !mdb[1];
        any  = !mdb[0] || !mdb[1];
        blk  = both || chq;
        evc  = both && !chq;
        for (int j = 0; j < 2; j++) begin
            evk[j] = 1'b0;
            if (mdb[j] || blk) begin
                nxt[j] = -1;
            end else if (mpress[j]) begin
                evk[j] = 1'b1;
                nxt[j] = mcyc + RD;
            end else if (nxt[j] == mcyc) begin
                evk[j] = 1'b1;
                nxt[j] = mcyc + RP;
            end
        end
        chq  = both || (chq && any);
        mcyc = mcyc + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
        cyc = cyc + 1;
        chk("inc0", 32'(bi0.inc), 32'(einc[0]));
        chk("dec0", 32'(bi0.dec), 32'(edec[0]));
        chk("lvl_rst0", 32'(bi0.lvl_rst), 32'(erst[0]));
        chk("held0", 32'(bi0.held), 32'({!mdb[1], !mdb[0]}));
        chk("inc1", 32'(bi1.inc), 32'(einc[1]));
        chk("dec1", 32'(bi1.dec), 32'(edec[1]));
        chk("lvl_rst1", 32'(bi1.lvl_rst), 32'(erst[1]));
        chk("held1", 32'(bi1.held), 32'({!mdb[1], !mdb[0]}));
        if (bi0.held != 2'b00) held_nz = held_nz + 1;
        if (bi0.inc) inc0.push_back(cyc);
        if (bi0.dec) dec0.push_back(cyc);
        if (bi0.lvl_rst) rst0.push_back(cyc);
        if (bi1.inc) inc1.push_back(cyc);
        if (bi1.dec) dec1.push_back(cyc);
        if (bi1.lvl_rst) rst1.push_back(cyc);
    endtask

    task automatic clrq();
        inc0.delete(); dec0.delete(); rst0.delete();
        inc1.delete(); dec1.delete(); rst1.delete();
    endtask

    task automatic frame();
        fs = 1'b1;
        tick();
        fs = 1'b0;
    endtask

    task automatic press(input bit up, input int n);
        if (up) ku = 1'b0; else kd = 1'b0;
        repeat (n) tick();
        ku = 1'b1;
        kd = 1'b1;
    endtask

    initial begin
        int c0, c1, e, len;
        int rpt_exp [6];
        rpt_exp = '{7, 27, 35, 43, 51, 59};
        model_reset();

        // reset state
        repeat (3) tick();
        chk("reset_inc", 32'(bi0.inc), 0);
        chk("reset_lvl_rst", 32'(bi1.lvl_rst), 0);
        chk("reset_held", 32'(bi0.held), 0);
        rst = 1'b1;
        repeat (3) tick();

        // bounce rejection, then a clean press
        for (int i = 0; i < 30; i++) begin
            ku = i[1];
            tick();
        end
        ku = 1'b1;
        repeat (10) tick();
        chk("bounce_inc", inc0.size(), 0);
        chk("bounce_held", held_nz, 0);
        c0 = cyc;
        press(1'b1, 10);
        repeat (20) tick();
        chk("press_cnt", inc0.size(), 1);
        chk("press_lat", (inc0.size() > 0) ? inc0[0] - c0 - 1 : -1, 7);

        // auto-repeat on the down key
        clrq();
        c0 = cyc;
        press(1'b0, 60);
        repeat (20) tick();
        chk("rpt_cnt", dec0.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("rpt_time", (i < dec0.size()) ? dec0[i] - c0 - 1 : -1, rpt_exp[i]);

        // frame alignment: early press, then a press landing on frame_start
        frame();
        repeat (5) tick();
        clrq();
        press(1'b1, 10);
        repeat (94) tick();
        frame();
        e = cyc;
        tick();
        chk("frame_cnt", inc1.size(), 1);
        chk("frame_time", (inc1.size() > 0) ? inc1[0] : -1, e);
        clrq();
        ku = 1'b0;
        repeat (6) tick();
        frame();
        repeat (4) tick();
        ku = 1'b1;
        repeat (30) tick();
        chk("coincident_held_back", inc1.size(), 0);
        frame();
        e = cyc;
        tick();
        chk("coincident_cnt", inc1.size(), 1);
        chk("coincident_time", (inc1.size() > 0) ? inc1[0] : -1, e);

        // merge two up events, cancel up against down
        clrq();
        press(1'b1, 8);
        repeat (8) tick();
        press(1'b1, 8);
        repeat (10) tick();
        frame();
        tick();
        chk("merge_inc", inc1.size(), 1);
        clrq();
        press(1'b1, 8);
        repeat (8) tick();
        press(1'b0, 8);
        repeat (10) tick();
        frame();
        tick();
        chk("cancel_inc", inc1.size(), 0);
        chk("cancel_dec", dec1.size(), 0);
        chk("cancel_lvl_rst", rst1.size(), 0);

        // chord, then partial release
        clrq();
        ku = 1'b0;
        tick();
        kd = 1'b0;
        repeat (30) tick();
        frame();
        repeat (19) tick();
        ku = 1'b1;
        repeat (20) tick();
        frame();
        tick();
        kd = 1'b1;
        repeat (20) tick();
        frame();
        tick();
        chk("chord_lvl_rst", rst1.size(), 1);
        chk("chord_inc", inc1.size(), 0);
        chk("chord_dec", dec1.size(), 0);

        // asynchronous reset during repeat with the key still held
        clrq();
        kd = 1'b0;
        repeat (28) tick();
        chk("pre_reset_dec", 32'(bi0.dec), 1);
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_dec", 32'(bi0.dec), 0);
        chk("async_held", 32'(bi0.held), 0);
        repeat (3) tick();
        c1 = cyc;
        rst = 1'b1;
        clrq();
        repeat (12) tick();
        kd = 1'b1;
        repeat (20) tick();
        chk("post_reset_lat", (dec0.size() > 0) ? dec0[0] - c1 - 1 : -1, 7);

        // randomized key levels and frame strobes
        for (int seg = 0; seg < 150; seg++) begin
            ku  = 1'($urandom_range(0, 1));
            kd  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 60);
            for (int i = 0; i < len; i++) begin
                fs = !fs && ($urandom_range(0, 9) == 0);
                tick();
            end
        end
        ku = 1'b1;
        kd = 1'b1;
        fs = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
